// File: rtl/i2s_rx.sv
// I2S (Philips format) receiver running as a clock slave in the clk domain.
// It oversamples sclk/lrclk/sdata, assembles MSB-first left/right words,
// aligns to a full left word after enable and queues stereo pairs in a
// small FIFO with a valid/ready stream and a sticky overflow flag.
module i2s_rx #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    en,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_l,
    output logic [SAMPLE_WIDTH-1:0] sample_r,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overflow,
    input  logic                    overflow_clr
);

    localparam int CNT_W  = $clog2(SAMPLE_WIDTH + 1);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } state_t;

    // Synchroniser stages, packed as {sclk, lrclk, sdata}
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;

    // Edge-detect stage: rise flag plus lrclk/sdata aligned with it
    logic sclk_prev_q, sclk_prev_d;
    logic rise_q, rise_d;
    logic ws_bit_q, ws_bit_d;
    logic data_bit_q, data_bit_d;

    // Word assembly and alignment
    state_t                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    ws_prev_q, ws_prev_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                    left_ok_q, left_ok_d;
    logic [SAMPLE_WIDTH-1:0] word;
    logic                    word_done;
    logic                    push_req;

    // Pair FIFO
    logic [SAMPLE_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_l_d [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_r_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_r_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    overflow_q, overflow_d;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    push_ok;

    // Two-flop synchronisers and a registered sclk rise with aligned ws/data
    always_comb begin
        meta_d      = {i2s_sclk, i2s_lrclk, i2s_sdata};
        sync_d      = meta_q;
        sclk_prev_d = sync_q[2];
        rise_d      = sync_q[2] & ~sclk_prev_q;
        ws_bit_d    = sync_q[1];
        data_bit_d  = sync_q[0];
    end

    // Bit placement, word completion and the IDLE/SYNC/RUN alignment rules
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ws_prev_d   = ws_prev_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        word        = shift_q;
        word_done   = 1'b0;
        push_req    = 1'b0;

        if (rise_q) begin
            ws_prev_d = ws_bit_q;
            for (int i = 0; i < SAMPLE_WIDTH; i++) begin
                if (int'(bit_cnt_q) == SAMPLE_WIDTH - 1 - i) begin
                    word[i] = data_bit_q;
                end
            end
            word_done = (ws_bit_q != ws_prev_q);
            if (word_done) begin
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d = word;
                if (bit_cnt_q != CNT_MAX) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (word_done && ws_prev_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (word_done) begin
                    if (!ws_prev_q) begin
                        left_hold_d = word;
                        left_ok_d   = 1'b1;
                    end else if (left_ok_q) begin
                        push_req  = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!en) begin
            state_d = ST_IDLE;
        end

        if (state_q == ST_IDLE) begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            left_hold_d = '0;
            left_ok_d   = 1'b0;
        end
    end

    // FIFO pointer update, storage write and sticky overflow (set beats clear)
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        pop        = !fifo_empty && sample_ready;
        push_ok    = push_req && (!fifo_full || pop);
        mem_l_d    = mem_l_q;
        mem_r_d    = mem_r_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push_ok) begin
            mem_l_d[wr_ptr_q[ADDR_W-1:0]] = left_hold_q;
            mem_r_d[wr_ptr_q[ADDR_W-1:0]] = word;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // All state registers, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            meta_q      <= '0;
            sync_q      <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            ws_bit_q    <= 1'b0;
            data_bit_q  <= 1'b0;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ws_prev_q   <= 1'b0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_l_q[i] <= '0;
                mem_r_q[i] <= '0;
            end
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
            rise_q      <= rise_d;
            ws_bit_q    <= ws_bit_d;
            data_bit_q  <= data_bit_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ws_prev_q   <= ws_prev_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            mem_l_q     <= mem_l_d;
            mem_r_q     <= mem_r_d;
        end
    end

    // Stream outputs: head pair, or zero while the FIFO is empty
    always_comb begin
        sample_valid = !fifo_empty;
        overflow     = overflow_q;
        sample_l     = '0;
        sample_r     = '0;
        if (!fifo_empty) begin
            sample_l = mem_l_q[rd_ptr_q[ADDR_W-1:0]];
            sample_r = mem_r_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver: the input-side counterpart of the I2S transmit pins (mclk/sclk/lrclk/sdata) the IO subsystem drives. Runs as a clock slave in the system `clk` domain, oversampling externally supplied `sclk`/`lrclk`/`sdata`. It assembles Philips-format left/right words MSB-first and delivers stereo sample pairs through a small FIFO with a valid/ready stream. It is used for codec/ADC input and for loopback verification of the audio transmit path.

## Interface
- `SAMPLE_WIDTH`, 24: bits stored per channel.
- `FIFO_DEPTH`, 4: stereo pairs buffered; power of two, at least 2.
- `clk` in 1: system clock; one clock; all logic is on the rising edge.
- `arstn` in 1: reset, asynchronous and active-low.
- `en` in 1: capture enable.
- `i2s_sclk` in 1: external bit clock, asynchronous to `clk`.
- `i2s_lrclk` in 1: word select; 0 = left, 1 = right.
- `i2s_sdata` in 1: serial data.
- `sample_l` out SAMPLE_WIDTH: left word at the FIFO head.
- `sample_r` out SAMPLE_WIDTH: right word at the FIFO head.
- `sample_valid` out 1: FIFO non-empty.
- `sample_ready` in 1: consumer accepts the head pair.
- `overflow` out 1: sticky flag; a pair was dropped.
- `overflow_clr` in 1: clears `overflow`.

## Operation
- Synchronisation: `sclk`, `lrclk` and `sdata` each pass through a 2-FF synchroniser.
- Rising-edge detect: `sclk_s` is 1 and its previous value was 0. All bit processing happens only on detected rising edges ("edge k").
- Channel of the bit sampled at edge k is `ws_prev`, the `lrclk_s` value latched at edge k-1.
  - If `lrclk_s != ws_prev` at edge k, this bit is the LSB of the `ws_prev` word and the word completes.
  - MSB of the new channel arrives at edge k+1 (one-bit I2S delay).
- Bit placement: per-word counter `bit_cnt` is cleared at word completion.
  - While `bit_cnt < SAMPLE_WIDTH`, the bit is written to position SAMPLE_WIDTH-1-bit_cnt.
  - Extra bits are ignored. `bit_cnt` saturates at SAMPLE_WIDTH.
  - Short words are zero-padded in the LSBs.
- Alignment states: IDLE -> SYNC -> RUN.
  - IDLE: `en`=0. Shift register, `bit_cnt`, `left_hold` and `left_ok` are cleared.
  - SYNC: entered when `en`=1. Waits for a word completion with `ws_prev`=1 (end of a right word), discarding data, then goes to RUN. This guarantees the first word captured in RUN is a full left word.
  - RUN:
    - Completed left word: goes to `left_hold`, sets `left_ok`.
    - Completed right word with `left_ok`=1: pushes pair {`left_hold`, word}, then clears `left_ok`.
    - Completed right word with `left_ok`=0: word discarded.
  - `en` falling in any state returns to IDLE on the next clk. The partial word is lost. FIFO contents and `overflow` are kept.
- FIFO:
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the pair is dropped and `overflow` is set.
  - Pop occurs on `sample_valid && sample_ready`.
  - Simultaneous push and pop on an empty FIFO: the push lands and `sample_valid` rises the next cycle (no bypass).
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap-around. Full = MSBs differ and the rest are equal.
- `overflow`:
  - Set and clear in the same cycle: set wins.
  - Cleared by `overflow_clr` otherwise.

## Timing
- Reset values:
  - `sample_valid` 0, `overflow` 0, `sample_l`/`sample_r` 0 (empty-FIFO head reads 0).
  - State IDLE, synchronisers 0.
- `sclk` high and low phases must each be at least 2 `clk` periods. Faster `sclk` is out of spec, with undefined data but no lockup.
- Latency: a raw `sclk` rise is captured at clk edge 0. Synchronised values are seen at edge 2, the edge is detected and the word completes at edge 3, and the FIFO is written at edge 3. `sample_valid`=1 after edge 3, i.e. it is visible during cycle 4.
- `sample_l`/`sample_r` are stable while `sample_valid`=1 and `sample_ready`=0.
- After a pop they update on the same edge that advances the read pointer.
- Throughput: one pair per stereo frame. The consumer may hold `sample_ready` low for up to FIFO_DEPTH frames without loss.
- Asynchronous reset mid-frame returns to IDLE. The first pair after release follows the SYNC rule.

## Test plan
- Enable, then send 3 frames of 32-bit words, L=0xA5A5A5xx and R=0x3C3C3Cxx: the first frame is consumed by SYNC, and 2 pairs are output with `sample_l`=0xA5A5A5 and `sample_r`=0x3C3C3C.
- 16-bit words, L=0x8001 and R=0x7FFF, SAMPLE_WIDTH=24: output L=0x800100, R=0x7FFF00.
- `sample_ready`=0 for 6 frames with FIFO_DEPTH=4: 4 pairs are held, `overflow`=1. The first 4 pairs are drained in order. Then `overflow_clr` is pulsed and `overflow` returns to 0.
- FIFO full with `sample_ready`=1 at the cycle a new pair completes: no drop, `overflow` stays 0, and the count stays 4.
- `en` dropped mid left word, then re-enabled: no partial pair is emitted, and the next output is the first complete L/R frame after a right-word completion.
- `arstn` pulsed mid-frame with the FIFO holding 2 pairs: `sample_valid`=0 and `overflow`=0 immediately, and normal capture resumes after SYNC.
- Latency check: single frame, FIFO empty. `sample_valid` rises exactly 4 clk after the raw `sclk` rise carrying the right LSB, with `sclk` = `clk`/4.
